// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the SCM16 ALU: request handshake, fixed settle window, response capture.
// Optional ALU_FLAGS_EN adds registered rsp_zero_o / rsp_neg_o flags.
`timescale 1ns / 1ps

module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned OPCODE_MAX    = 11,
  parameter int unsigned TAG_W         = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_op_i,
  input  logic [15:0]      req_a_i,
  input  logic [15:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [15:0]      alu_instruction_o,
  output logic [15:0]      alu_input_1_o,
  output logic [15:0]      alu_input_2_o,
  output logic             alu_enable_o,
  input  logic [15:0]      alu_output_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [15:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
`ifdef ALU_FLAGS_EN
  output logic             rsp_zero_o,
  output logic             rsp_neg_o,
`endif
  output logic             rsp_dz_o
);

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] OpMax   = 5'(OPCODE_MAX);

  typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [15:0]        data_q, data_d;
  logic               err_q, err_d;
  logic               dz_q, dz_d;
`ifdef ALU_FLAGS_EN
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    dz_d    = dz_q;
`ifdef ALU_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d  = req_op_i;
          a_d   = req_a_i;
          b_d   = req_b_i;
          tag_d = req_tag_i;
          dz_d  = ((req_op_i == 4'd3) || (req_op_i == 4'd4)) && (req_b_i == 16'h0000);
          if ({1'b0, req_op_i} > OpMax) begin
            // Illegal opcode never touches the ALU; respond immediately with an error.
            state_d = StHold;
            data_d  = 16'h0000;
            err_d   = 1'b1;
`ifdef ALU_FLAGS_EN
            zero_d  = 1'b0;
            neg_d   = 1'b0;
`endif
          end else begin
            state_d = StDrive;
            cnt_d   = CntInit;
            err_d   = 1'b0;
          end
        end
      end
      StDrive: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = alu_output_i;
`ifdef ALU_FLAGS_EN
          zero_d  = (alu_output_i == 16'h0000);
          neg_d   = alu_output_i[15];
`endif
          state_d = StHold;
        end
      end
      StHold: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      tag_q   <= '0;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
`ifdef ALU_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
`endif
    end
  end

  // ALU ports are quiet (all zero) whenever the ALU is not being driven.
  always_comb begin
    req_ready_o       = (state_q == StIdle);
    rsp_valid_o       = (state_q == StHold);
    alu_enable_o      = (state_q == StDrive);
    alu_instruction_o = alu_enable_o ? {12'h000, op_q} : 16'h0000;
    alu_input_1_o     = alu_enable_o ? a_q : 16'h0000;
    alu_input_2_o     = alu_enable_o ? b_q : 16'h0000;
  end

  assign rsp_data_o = data_q;
  assign rsp_tag_o  = tag_q;
  assign rsp_err_o  = err_q;
  assign rsp_dz_o   = dz_q;
`ifdef ALU_FLAGS_EN
  assign rsp_zero_o = zero_q;
  assign rsp_neg_o  = neg_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table through a scoreboard, plus backpressure,
// illegal-opcode and reset-during-drive sequences. A behavioural ALU sits on the ALU ports.
`timescale 1ns / 1ps

module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, settle window of 1
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b, alu_ins, alu_in1, alu_in2, alu_out, rsp_data;
  logic [2:0]  req_tag, rsp_tag;
  logic        alu_en, rsp_err, rsp_dz;
  // Second DUT, settle window of 4
  logic        r4_rst_n;
  logic        r4_req_valid, r4_req_ready, r4_rsp_valid, r4_rsp_ready;
  logic [3:0]  r4_req_op;
  logic [15:0] r4_req_a, r4_req_b, r4_alu_ins, r4_alu_in1, r4_alu_in2, r4_alu_out, r4_rsp_data;
  logic [2:0]  r4_req_tag, r4_rsp_tag;
  logic        r4_alu_en, r4_rsp_err, r4_rsp_dz;
`ifdef ALU_FLAGS_EN
  logic        rsp_zero, rsp_neg, r4_rsp_zero, r4_rsp_neg;
`endif

  function automatic logic [15:0] alu_model(input logic [15:0] ins, a, b);
    logic [7:0] sh;
    sh = b[7:0];
    case (ins[3:0])
      4'd0:    return a << sh;
      4'd1:    return a >> sh;
      4'd2:    return 16'($signed(a) >>> sh);
      4'd3:    return (b == 16'h0) ? 16'h0 : a % b;
      4'd4:    return (b == 16'h0) ? a : a / b;
      4'd5:    return 16'(a * b);
      4'd6:    return a - b;
      4'd7:    return a + b;
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return a ^ b;
      4'd11:   return ~a;
      default: return 16'hBAD0;
    endcase
  endfunction

  // Junk when not enabled so a capture outside the drive window is visible.
  assign alu_out    = alu_en ? alu_model(alu_ins, alu_in1, alu_in2) : 16'hDEAD;
  assign r4_alu_out = r4_alu_en ? alu_model(r4_alu_ins, r4_alu_in1, r4_alu_in2) : 16'hDEAD;

  alu_issue_ctrl #(.SETTLE_CYCLES(1), .OPCODE_MAX(11), .TAG_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .alu_instruction_o(alu_ins), .alu_input_1_o(alu_in1), .alu_input_2_o(alu_in2),
    .alu_enable_o(alu_en), .alu_output_i(alu_out),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
`ifdef ALU_FLAGS_EN
    .rsp_zero_o(rsp_zero), .rsp_neg_o(rsp_neg),
`endif
    .rsp_dz_o(rsp_dz)
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(4), .OPCODE_MAX(11), .TAG_W(3)) dut4 (
    .clk_i(clk), .rst_ni(r4_rst_n),
    .req_valid_i(r4_req_valid), .req_ready_o(r4_req_ready), .req_op_i(r4_req_op),
    .req_a_i(r4_req_a), .req_b_i(r4_req_b), .req_tag_i(r4_req_tag),
    .alu_instruction_o(r4_alu_ins), .alu_input_1_o(r4_alu_in1), .alu_input_2_o(r4_alu_in2),
    .alu_enable_o(r4_alu_en), .alu_output_i(r4_alu_out),
    .rsp_valid_o(r4_rsp_valid), .rsp_ready_i(r4_rsp_ready), .rsp_data_o(r4_rsp_data),
    .rsp_tag_o(r4_rsp_tag), .rsp_err_o(r4_rsp_err),
`ifdef ALU_FLAGS_EN
    .rsp_zero_o(r4_rsp_zero), .rsp_neg_o(r4_rsp_neg),
`endif
    .rsp_dz_o(r4_rsp_dz)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
    logic [15:0] data;
    logic        err;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  tag;
    logic        err;
    logic        dz;
  } rsp_t;

  localparam int NumVec = 16;
  vec_t vecs[NumVec];
  rsp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input vec_t v);
    rsp_t r;
    r.data = v.data;
    r.tag  = v.tag;
    r.err  = v.err;
    r.dz   = v.dz;
    sb_q.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, req_ready, 1'b1);
  endtask

  // Issue one request from IDLE; count edges from presentation until rsp_valid.
  task automatic send(input vec_t v, input int exp_lat);
    int lat = 0;
    bit saw_en = 1'b0;
    chk("req_ready_before_issue", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_tag   = v.tag;
    push_exp(v);
    do begin
      @(posedge clk); #1;
      lat++;
      req_valid = 1'b0;
      if (alu_en) saw_en = 1'b1;
    end while (!rsp_valid && lat < 40);
    chk("latency", lat, exp_lat);
    if (v.err) chk("illegal_no_enable", saw_en, 1'b0);
    else       chk("legal_saw_enable", saw_en, 1'b1);
    wait_idle("return_to_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp0, bp1;
    int   n;
    bit   seen;

    vecs[0]  = '{4'd7,  16'h1234, 16'h0001, 3'd1, 16'h1235, 1'b0, 1'b0};
    vecs[1]  = '{4'd6,  16'h0005, 16'h0007, 3'd2, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{4'd4,  16'd100,  16'h0000, 3'd3, 16'd100,  1'b0, 1'b1};
    vecs[3]  = '{4'd3,  16'd100,  16'h0000, 3'd4, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{4'd13, 16'h0001, 16'h0002, 3'd5, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{4'd0,  16'h0001, 16'h0104, 3'd6, 16'h0010, 1'b0, 1'b0};
    vecs[6]  = '{4'd2,  16'h8000, 16'h0003, 3'd7, 16'hF000, 1'b0, 1'b0};
    vecs[7]  = '{4'd5,  16'h0100, 16'h0100, 3'd0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{4'd11, 16'h00FF, 16'h1234, 3'd1, 16'hFF00, 1'b0, 1'b0};
    vecs[9]  = '{4'd10, 16'hAAAA, 16'hFFFF, 3'd2, 16'h5555, 1'b0, 1'b0};
    vecs[10] = '{4'd12, 16'h0009, 16'h0000, 3'd7, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{4'd3,  16'd17,   16'd5,    3'd3, 16'd2,    1'b0, 1'b0};
    vecs[12] = '{4'd4,  16'h0000, 16'h0000, 3'd4, 16'h0000, 1'b0, 1'b1};
    vecs[13] = '{4'd1,  16'h8000, 16'h000F, 3'd5, 16'h0001, 1'b0, 1'b0};
    vecs[14] = '{4'd8,  16'hF0F0, 16'h3C3C, 3'd6, 16'h3030, 1'b0, 1'b0};
    vecs[15] = '{4'd9,  16'hF0F0, 16'h3C3C, 3'd0, 16'hFCFC, 1'b0, 1'b0};

    rst_n = 1'b1; r4_rst_n = 1'b1;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;
    r4_req_valid = 1'b0; r4_req_op = '0; r4_req_a = '0; r4_req_b = '0; r4_req_tag = '0;
    r4_rsp_ready = 1'b1;
    #2 rst_n = 1'b0; r4_rst_n = 1'b0;
    #1;
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_alu_enable", alu_en, 1'b0);
    chk("reset_alu_ports", {alu_ins, alu_in1}, 32'h0);
    chk("reset_rsp_data", rsp_data, 16'h0);
    chk("reset_rsp_flags", {rsp_err, rsp_dz, rsp_tag}, 5'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; r4_rst_n = 1'b1;
    @(posedge clk); #1;

    // Scoreboard monitor: pops on each response handshake, also checks ALU ports idle to zero.
    fork
      forever begin
        rsp_t e;
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response: got data %h tag %0d expected none", rsp_data,
                     rsp_tag);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_dz", rsp_dz, e.dz);
`ifdef ALU_FLAGS_EN
            chk("rsp_zero", rsp_zero, !e.err && (e.data == 16'h0));
            chk("rsp_neg", rsp_neg, !e.err && e.data[15]);
`endif
          end
        end
        if (!alu_en) chk("alu_ports_idle_zero", {alu_ins | alu_in1 | alu_in2}, 32'h0);
      end
    join_none

    for (int i = 0; i < NumVec; i++) send(vecs[i], vecs[i].err ? 1 : 2);

    // Backpressure: response held 5 cycles while a second request waits.
    bp0 = '{4'd7,  16'h0010, 16'h0020, 3'd6, 16'h0030, 1'b0, 1'b0};
    bp1 = '{4'd10, 16'h00FF, 16'h0F0F, 3'd2, 16'h0FF0, 1'b0, 1'b0};
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = bp0.op; req_a = bp0.a; req_b = bp0.b; req_tag = bp0.tag;
    push_exp(bp0);
    @(posedge clk); #1;
    chk("bp_accept", req_ready, 1'b0);
    req_op = bp1.op; req_a = bp1.a; req_b = bp1.b; req_tag = bp1.tag;
    push_exp(bp1);
    @(posedge clk); #1;
    chk("bp_rsp_valid_rise", rsp_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, bp0.data);
      chk("bp_hold_tag", rsp_tag, bp0.tag);
      chk("bp_hold_err_dz", {rsp_err, rsp_dz}, 2'b00);
      chk("bp_req_ready_low", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_hs_ready", req_ready, 1'b1);
    chk("bp_after_hs_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    chk("bp_second_accepted", req_ready, 1'b0);
    chk("bp_second_enable", alu_en, 1'b1);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_second_latency", n, 1);
    wait_idle("bp_return_idle");

    // Settle window of 4: latency check.
    chk("r4_ready", r4_req_ready, 1'b1);
    r4_req_valid = 1'b1; r4_req_op = 4'd7; r4_req_a = 16'd3; r4_req_b = 16'd4; r4_req_tag = 3'd3;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      r4_req_valid = 1'b0;
    end while (!r4_rsp_valid && n < 40);
    chk("r4_latency", n, 5);
    chk("r4_data", r4_rsp_data, 16'd7);
    chk("r4_tag", r4_rsp_tag, 3'd3);
    @(posedge clk); #1;
    chk("r4_idle", r4_req_ready, 1'b1);

    // Reset after two drive cycles: everything drops, no response afterwards.
    r4_req_valid = 1'b1; r4_req_op = 4'd7; r4_req_a = 16'd1; r4_req_b = 16'd2; r4_req_tag = 3'd1;
    @(posedge clk); #1;
    r4_req_valid = 1'b0;
    chk("r4_drive1_enable", r4_alu_en, 1'b1);
    @(posedge clk); #1;
    chk("r4_drive2_enable", r4_alu_en, 1'b1);
    r4_rst_n = 1'b0;
    #1;
    chk("r4_rst_enable", r4_alu_en, 1'b0);
    chk("r4_rst_valid", r4_rsp_valid, 1'b0);
    chk("r4_rst_ready", r4_req_ready, 1'b1);
    chk("r4_rst_ports", {r4_alu_ins, r4_alu_in1}, 32'h0);
    @(negedge clk);
    r4_rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (r4_rsp_valid || r4_alu_en) seen = 1'b1;
    end
    chk("r4_no_response_after_reset", seen, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
